ws2812_frame_sequencer: RTL and testbench

Upstream feeder for the WS2812 bit controller: holds a frame of NUM_LEDS 24-bit GRB pixel words in a flop array, and on request streams them word-by-word into the bit controller's `indata`/`reset` load interface. After the last word it enforces the WS2812 latch (line-idle) interval before signalling frame completion. It sits between host/pattern logic (pixel writes, frame start) and the bit controller, replacing the free-running counter stimulus in the top level.

---
 rtl/ws2812_frame_sequencer.sv | 129 ++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_sequencer.sv
// Frame buffer and word sequencer that feeds the WS2812 bit controller load interface.
// Build option WS2812_AUTO_REFRESH_EN: restart from pixel 0 at each latch end instead of idling.
module ws2812_frame_sequencer #(
   parameter int F_CLK    = 12_000_000,
   parameter int NUM_LEDS = 8,
   parameter int LATCH_US = 80
) (
   input  logic                                               CLK_IN,
   input  logic                                               RESET_N,
   input  logic                                               WR_EN,
   input  logic [((NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1)-1:0] WR_ADDR,
   input  logic [23:0]                                        WR_DATA,
   input  logic                                               START,
   output logic                                               BUSY,
   output logic                                               FRAME_DONE,
   output logic [23:0]                                        BIT_DATA,
   output logic                                               BIT_LOAD,
   input  logic                                               BIT_DONE
);

   localparam int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam int LATCH_CYCLES = (F_CLK / 1_000_000) * LATCH_US;
   // FRAME_DONE is itself a flop, so the counter stops one short of LATCH_CYCLES-1
   localparam int LATCH_LAST   = (LATCH_CYCLES > 1) ? LATCH_CYCLES - 2 : 0;
   localparam int CW           = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_LATCH = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] idx_q, idx_d, idx_inc;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   mem_q [NUM_LEDS];
   logic [23:0]   mem_d [NUM_LEDS];
   logic [23:0]   bit_data_q, bit_data_d;
   logic          bit_load_q, bit_load_d;
   logic          busy_q, busy_d;
   logic          frame_done_q, frame_done_d;

   assign idx_inc = idx_q + AW'(1);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      bit_data_d   = bit_data_q;
      bit_load_d   = 1'b0;
      busy_d       = busy_q;
      frame_done_d = 1'b0;
      mem_d        = mem_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               bit_data_d = mem_q[0];
               bit_load_d = 1'b1;
               idx_d      = '0;
               busy_d     = 1'b1;
               state_d    = ST_ARM;
            end
         end
         // done is still stale from the previous word while the load lands
         ST_ARM: state_d = ST_WAIT;
         ST_WAIT: begin
            if (BIT_DONE) begin
               if (idx_q == LAST_IDX) begin
                  cnt_d   = '0;
                  state_d = ST_LATCH;
               end else begin
                  idx_d      = idx_inc;
                  bit_data_d = mem_q[idx_inc];
                  bit_load_d = 1'b1;
                  state_d    = ST_ARM;
               end
            end
         end
         default: begin
            if (cnt_q == CW'(LATCH_LAST)) begin
               frame_done_d = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
               bit_data_d = mem_q[0];
               bit_load_d = 1'b1;
               idx_d      = '0;
               state_d    = ST_ARM;
`else
               busy_d  = 1'b0;
               state_d = ST_IDLE;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
      endcase

      // Reads above use mem_q, so a same-cycle write to the loaded pixel sends the old word
      if (WR_EN && (32'(WR_ADDR) < NUM_LEDS)) mem_d[WR_ADDR] = WR_DATA;
   end

   always_ff @(posedge CLK_IN) begin
      if (!RESET_N) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         bit_data_q   <= '0;
         bit_load_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < NUM_LEDS; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         bit_data_q   <= bit_data_d;
         bit_load_q   <= bit_load_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         mem_q        <= mem_d;
      end
   end

   assign BUSY       = busy_q;
   assign FRAME_DONE = frame_done_q;
   assign BIT_DATA   = bit_data_q;
   assign BIT_LOAD   = bit_load_q;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Randomized bench for ws2812_frame_sequencer: event-level reference model plus a bit-controller stand-in.
module tb_ws2812_frame_sequencer;

   localparam int N     = 3;
   localparam int LATCH = 960;

   logic        CLK_IN   = 1'b0;
   logic        RESET_N  = 1'b0;
   logic        WR_EN    = 1'b0;
   logic [1:0]  WR_ADDR  = '0;
   logic [23:0] WR_DATA  = '0;
   logic        START    = 1'b0;
   logic        BIT_DONE = 1'b1;
   logic        BUSY, FRAME_DONE, BIT_LOAD;
   logic [23:0] BIT_DATA;

   int n_chk  = 0;
   int n_pass = 0;

   ws2812_frame_sequencer #(.NUM_LEDS(N)) dut (
      .CLK_IN(CLK_IN), .RESET_N(RESET_N), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .START(START), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .BIT_DATA(BIT_DATA),
      .BIT_LOAD(BIT_LOAD), .BIT_DONE(BIT_DONE)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Reference model: frame rules applied as events at each rising edge
   logic [23:0] mdl_mem [N];
   int          edge_n    = 0;
   int          load_edge = 0;
   int          latch_end = -1;
   int          pix       = 0;
   logic        active    = 1'b0;
   logic        rst_now   = 1'b0;
   logic        exp_load  = 1'b0;
   logic        exp_fd    = 1'b0;
   logic [23:0] exp_data  = '0;

   always @(posedge CLK_IN) begin
      edge_n++;
      exp_load = 1'b0;
      exp_fd   = 1'b0;
      rst_now  = !RESET_N;
      if (!RESET_N) begin
         foreach (mdl_mem[i]) mdl_mem[i] = '0;
         active    = 1'b0;
         latch_end = -1;
         exp_data  = '0;
      end else begin
         if (!active) begin
            if (START) begin
               active = 1'b1; pix = 0; exp_load = 1'b1; exp_data = mdl_mem[0]; load_edge = edge_n;
            end
         end else if (latch_end == edge_n) begin
            exp_fd    = 1'b1;
            latch_end = -1;
`ifdef WS2812_AUTO_REFRESH_EN
            pix = 0; exp_load = 1'b1; exp_data = mdl_mem[0]; load_edge = edge_n;
`else
            active = 1'b0;
`endif
         end else if (latch_end < 0 && BIT_DONE && edge_n > load_edge + 1) begin
            if (pix == N - 1) latch_end = edge_n + LATCH - 1;
            else begin
               pix++; exp_load = 1'b1; exp_data = mdl_mem[pix]; load_edge = edge_n;
            end
         end
         if (WR_EN && int'(WR_ADDR) < N) mdl_mem[WR_ADDR] = WR_DATA;
      end
   end

   // Monitor plus bit-controller stand-in, all on the falling edge
   int          nc = 0, fd_cnt = 0, load_cnt = 0, frame_loads = 0;
   int          dly_fixed = 0, done_ctr = 0, done_nc = 0, fd_nc = 0;
   logic        prev_load = 1'b0;
   logic [23:0] sent [N];

   initial begin
      foreach (sent[i]) sent[i] = '0;
      forever begin
         @(negedge CLK_IN);
         nc++;
         chk("bit_load", 32'(BIT_LOAD), 32'(exp_load));
         chk("bit_data", 32'(BIT_DATA), 32'(exp_data));
         chk("frame_done", 32'(FRAME_DONE), 32'(exp_fd));
         chk("busy", 32'(BUSY), 32'(active));
         chk("load_b2b", 32'(BIT_LOAD & prev_load), 32'(0));
         if (rst_now) frame_loads = 0;
         if (FRAME_DONE) begin
            chk("loads_per_frame", frame_loads, N);
            frame_loads = 0; fd_cnt++; fd_nc = nc;
         end
         if (BIT_LOAD) begin
            if (frame_loads < N) sent[frame_loads] = BIT_DATA;
            frame_loads++; load_cnt++;
            BIT_DONE = 1'b0;
            done_ctr = (dly_fixed > 0) ? dly_fixed : int'($urandom_range(1, 25));
         end else if (done_ctr > 0) begin
            done_ctr--;
            if (done_ctr == 0) begin BIT_DONE = 1'b1; done_nc = nc; end
         end
         prev_load = BIT_LOAD;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK_IN);
   endtask

   task automatic pulse_start();
      START = 1'b1; tick(1); START = 1'b0;
   endtask

   task automatic wr(input int a, input logic [23:0] d);
      WR_EN = 1'b1; WR_ADDR = a[1:0]; WR_DATA = d; tick(1); WR_EN = 1'b0;
   endtask

   task automatic do_reset(input int n);
      RESET_N = 1'b0; tick(n); RESET_N = 1'b1;
   endtask

   task automatic wait_fd(input string tag, input int budget);
      int target = fd_cnt + 1;
      for (int i = 0; i < budget && fd_cnt < target; i++) @(negedge CLK_IN);
      chk(tag, 32'(fd_cnt >= target), 32'(1));
   endtask

   task automatic wait_loads(input string tag, input int target, input int budget);
      for (int i = 0; i < budget && load_cnt < target; i++) @(negedge CLK_IN);
      chk(tag, 32'(load_cnt >= target), 32'(1));
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          fb, lb;
      logic [23:0] new0;

      // Reset dominates START and a write
      RESET_N = 1'b0; START = 1'b1; WR_EN = 1'b1; WR_ADDR = 2'd1; WR_DATA = 24'hABCDEF;
      tick(3);
      chk("rst_busy", 32'(BUSY), 32'(0));
      chk("rst_load", 32'(BIT_LOAD), 32'(0));
      chk("rst_data", 32'(BIT_DATA), 32'(0));
      RESET_N = 1'b1; START = 1'b0; WR_EN = 1'b0;
      tick(2);
      pulse_start();
      wait_fd("fd_zero_frame", 3000);
      chk("rst_write_dropped", 32'(sent[1]), 32'(0));

      // Fixed pattern, 720-cycle words, stray STARTs in WAIT and LATCH
      do_reset(1);
      wr(0, 24'hFF0000); wr(1, 24'h00FF00); wr(2, 24'h0000FF); wr(3, 24'($urandom));
      dly_fixed = 720;
      fb = fd_cnt; lb = load_cnt;
      pulse_start();
      tick(100); pulse_start();
      wait_loads("frame_a_loads", lb + 3, 3000);
      tick(900); pulse_start();
      wait_fd("fd_frame_a", 2000);
      chk("latch_len", fd_nc - done_nc, LATCH);
      chk("px0", 32'(sent[0]), 32'hFF0000);
      chk("px1", 32'(sent[1]), 32'h00FF00);
      chk("px2", 32'(sent[2]), 32'h0000FF);
      tick(30);
      chk("single_fd", fd_cnt - fb, 1);
`ifdef WS2812_AUTO_REFRESH_EN
      chk("busy_after_fd", 32'(BUSY), 32'(1));
`else
      chk("busy_after_fd", 32'(BUSY), 32'(0));
      chk("no_extra_loads", load_cnt - lb, 3);
`endif

      // Mid-frame writes: ahead of the pointer now, behind it next frame
      do_reset(1);
      dly_fixed = 0;
      wr(0, 24'h111111); wr(1, 24'h222222); wr(2, 24'h333333);
      new0 = 24'($urandom);
      lb = load_cnt;
      pulse_start();
      wait_loads("frame_b_first", lb + 1, 100);
      wr(2, 24'h123456);
      wr(0, new0);
      wr(3, 24'($urandom));
      wait_fd("fd_frame_b", 3000);
      chk("late_write_px2", 32'(sent[2]), 32'h123456);
      chk("early_write_px0", 32'(sent[0]), 32'h111111);
      pulse_start();
      wait_fd("fd_frame_c", 3000);
      chk("next_frame_px0", 32'(sent[0]), 32'(new0));
      chk("addr_oob_ignored", 32'(sent[1]), 32'h222222);

      // Reset during pixel 1 aborts; its late done is ignored
      do_reset(1);
      dly_fixed = 40;
      lb = load_cnt;
      pulse_start();
      wait_loads("abort_px1", lb + 2, 200);
      tick(10);
      do_reset(1);
      fb = fd_cnt; lb = load_cnt;
      tick(80);
      chk("abort_no_load", load_cnt - lb, 0);
      chk("abort_no_fd", fd_cnt - fb, 0);
      pulse_start();
      tick(1);
      chk("restart_load", load_cnt - lb, 1);
      chk("restart_px0", 32'(sent[0]), 32'(0));
      wait_fd("fd_restart", 3000);

      // Random traffic against the model
      dly_fixed = 0;
      do_reset(1);
      for (int i = 0; i < 5000; i++) begin
         START   = ($urandom_range(0, 19) == 0);
         WR_EN   = ($urandom_range(0, 3) == 0);
         WR_ADDR = 2'($urandom_range(0, 3));
         WR_DATA = 24'($urandom);
         RESET_N = (i != 2600);
         tick(1);
      end
      START = 1'b0; WR_EN = 1'b0; RESET_N = 1'b1;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
